// File: rtl/mul_exec_pipe.sv
// Three-stage integer multiplier (MUL/MULH/MULHSU/MULHU) for the mul result bus.
// Ports: issue/operands/sideband in, branch resolve in, exrslt/exdst/flags out.
module mul_exec_pipe #(
  parameter int DATA_LEN    = 32,
  parameter int RRF_SEL     = 6,
  parameter int SPECTAG_LEN = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   issue,
  input  logic [DATA_LEN-1:0]    ex_src1,
  input  logic [DATA_LEN-1:0]    ex_src2,
  input  logic                   src1_signed,
  input  logic                   src2_signed,
  input  logic                   sel_lohi,
  input  logic [RRF_SEL-1:0]     rrftag,
  input  logic                   dstval,
  input  logic [SPECTAG_LEN-1:0] spectag,
  input  logic                   specbit,
  input  logic                   prmiss,
  input  logic                   prsuccess,
  input  logic [SPECTAG_LEN-1:0] prtag,
  input  logic [SPECTAG_LEN-1:0] specfixtag,
  output logic                   result_valid,
  output logic [DATA_LEN-1:0]    exrslt,
  output logic [RRF_SEL-1:0]     exdst,
  output logic                   rrf_we,
  output logic                   kill_spec,
  output logic                   out_specbit,
  output logic                   pipe_busy
);

  localparam int PW = 2 * DATA_LEN;

  logic                   v1, v2, v3;
  logic [DATA_LEN:0]      a1, b1;
  logic [PW-1:0]          p2;
  logic [SPECTAG_LEN-1:0] t1, t2, t3;
  logic                   sb1, sb2, sb3;
  logic [RRF_SEL-1:0]     d1, d2, d3;
  logic                   dv1, dv2, dv3;
  logic                   lh1, lh2;
  logic [DATA_LEN-1:0]    r3;

  // Squash test and speculation-clear test for an op carrying tag t.
  function automatic logic hit(input logic [SPECTAG_LEN-1:0] t);
    return prmiss & (|(t & specfixtag));
  endfunction

  function automatic logic clr(input logic [SPECTAG_LEN-1:0] t);
    return prsuccess & (t == prtag);
  endfunction

  // Sign-extend the 33-bit operands to the product width; the low
  // 2*DATA_LEN bits of this product equal the truncated full product.
  logic [PW-1:0] a_ext, b_ext, prod;
  assign a_ext = {{(PW-DATA_LEN-1){a1[DATA_LEN]}}, a1};
  assign b_ext = {{(PW-DATA_LEN-1){b1[DATA_LEN]}}, b1};
  assign prod  = a_ext * b_ext;

  always_ff @(posedge clk) begin
    if (reset) begin
      v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0;
      a1 <= '0;   b1 <= '0;   p2 <= '0;  r3 <= '0;
      t1 <= '0;   t2 <= '0;   t3 <= '0;
      sb1 <= 1'b0; sb2 <= 1'b0; sb3 <= 1'b0;
      d1 <= '0;   d2 <= '0;   d3 <= '0;
      dv1 <= 1'b0; dv2 <= 1'b0; dv3 <= 1'b0;
      lh1 <= 1'b0; lh2 <= 1'b0;
    end else begin
      v1 <= issue & ~hit(spectag);
      v2 <= v1 & ~hit(t1);
      v3 <= v2 & ~hit(t2);
      if (issue) begin
        a1  <= {src1_signed & ex_src1[DATA_LEN-1], ex_src1};
        b1  <= {src2_signed & ex_src2[DATA_LEN-1], ex_src2};
        t1  <= spectag;
        sb1 <= specbit & ~clr(spectag);
        d1  <= rrftag;
        dv1 <= dstval;
        lh1 <= sel_lohi;
      end
      if (v1) begin
        p2  <= prod;
        t2  <= t1;
        sb2 <= sb1 & ~clr(t1);
        d2  <= d1;
        dv2 <= dv1;
        lh2 <= lh1;
      end
      if (v2) begin
        r3  <= lh2 ? p2[PW-1:DATA_LEN] : p2[DATA_LEN-1:0];
        t3  <= t2;
        sb3 <= sb2 & ~clr(t2);
        d3  <= d2;
        dv3 <= dv2;
      end
    end
  end

  assign result_valid = v3;
  assign exrslt       = r3;
  assign exdst        = d3;
  assign rrf_we       = v3 & dv3;
  assign kill_spec    = v3 & hit(t3);
  assign out_specbit  = sb3;
  assign pipe_busy    = v1 | v2 | v3;

endmodule

// File: tb/tb_mul_exec_pipe.sv
// Directed self-checking bench for mul_exec_pipe.
// Linear stimulus, immediate assertions at each check point.
module tb_mul_exec_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue;
  logic [31:0] ex_src1, ex_src2;
  logic        src1_signed, src2_signed, sel_lohi;
  logic [5:0]  rrftag;
  logic        dstval;
  logic [4:0]  spectag;
  logic        specbit;
  logic        prmiss, prsuccess;
  logic [4:0]  prtag, specfixtag;
  logic        result_valid;
  logic [31:0] exrslt;
  logic [5:0]  exdst;
  logic        rrf_we, kill_spec, out_specbit, pipe_busy;

  int vectors = 0;
  int miscompares = 0;
  int busy_cnt;

  mul_exec_pipe dut (
    .clk(clk), .reset(reset), .issue(issue),
    .ex_src1(ex_src1), .ex_src2(ex_src2),
    .src1_signed(src1_signed), .src2_signed(src2_signed),
    .sel_lohi(sel_lohi), .rrftag(rrftag), .dstval(dstval),
    .spectag(spectag), .specbit(specbit),
    .prmiss(prmiss), .prsuccess(prsuccess),
    .prtag(prtag), .specfixtag(specfixtag),
    .result_valid(result_valid), .exrslt(exrslt), .exdst(exdst),
    .rrf_we(rrf_we), .kill_spec(kill_spec),
    .out_specbit(out_specbit), .pipe_busy(pipe_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    issue = 1'b0; prmiss = 1'b0; prsuccess = 1'b0;
    prtag = '0; specfixtag = '0;
  endtask

  task automatic set_op(input logic [31:0] a, input logic [31:0] b,
                        input logic sa, input logic sb, input logic hi,
                        input logic [5:0] dst, input logic dv,
                        input logic [4:0] tag, input logic spec);
    issue = 1'b1; ex_src1 = a; ex_src2 = b;
    src1_signed = sa; src2_signed = sb; sel_lohi = hi;
    rrftag = dst; dstval = dv; spectag = tag; specbit = spec;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rv"}, {31'd0, result_valid}, 32'd0);
    chk({tag, "_rslt"}, exrslt, 32'd0);
    chk({tag, "_dst"}, {26'd0, exdst}, 32'd0);
    chk({tag, "_we"}, {31'd0, rrf_we}, 32'd0);
    chk({tag, "_kill"}, {31'd0, kill_spec}, 32'd0);
    chk({tag, "_spec"}, {31'd0, out_specbit}, 32'd0);
    chk({tag, "_busy"}, {31'd0, pipe_busy}, 32'd0);
  endtask

  initial begin
    idle();
    set_op('0, '0, 0, 0, 0, '0, 0, '0, 0);
    issue = 1'b0;
    reset = 1'b1;
    tick(); tick();
    chk_zero("reset");
    reset = 1'b0;

    // MUL lo unsigned: 3*5 = 15
    set_op(32'd3, 32'd5, 0, 0, 0, 6'd7, 1, 5'b0, 0);
    tick(); idle();
    chk("mul_busy", {31'd0, pipe_busy}, 32'd1);
    chk("mul_rv_e0", {31'd0, result_valid}, 32'd0);
    tick();
    chk("mul_rv_e1", {31'd0, result_valid}, 32'd0);
    tick();
    chk("mul_rv", {31'd0, result_valid}, 32'd1);
    chk("mul_we", {31'd0, rrf_we}, 32'd1);
    chk("mul_rslt", exrslt, 32'h0000_000F);
    chk("mul_dst", {26'd0, exdst}, 32'd7);
    tick();
    chk("mul_rv_after", {31'd0, result_valid}, 32'd0);
    chk("mul_busy_after", {31'd0, pipe_busy}, 32'd0);

    // MULH / MULHU / MULHSU of -1 x -1, back to back
    set_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1, 1, 6'd10, 1, 5'b0, 0);
    tick();
    set_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1, 6'd11, 1, 5'b0, 0);
    tick();
    set_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 1, 6'd12, 0, 5'b0, 0);
    tick(); idle();
    chk("mulh_rslt", exrslt, 32'h0000_0000);
    chk("mulh_dst", {26'd0, exdst}, 32'd10);
    tick();
    chk("mulhu_rslt", exrslt, 32'hFFFF_FFFE);
    chk("mulhu_dst", {26'd0, exdst}, 32'd11);
    tick();
    chk("mulhsu_rslt", exrslt, 32'hFFFF_FFFF);
    chk("mulhsu_rv", {31'd0, result_valid}, 32'd1);
    chk("mulhsu_we", {31'd0, rrf_we}, 32'd0);
    tick(); tick();

    // Four back-to-back ops: (k)*2 with tags k = 1..4
    busy_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      if (c < 4)
        set_op(c + 1, 32'd2, 0, 0, 0, 6'(c + 1), 1, 5'b0, 0);
      else
        idle();
      tick();
      if (pipe_busy) busy_cnt++;
      if (c >= 2 && c <= 5) begin
        chk("b2b_rv", {31'd0, result_valid}, 32'd1);
        chk("b2b_dst", {26'd0, exdst}, c - 1);
        chk("b2b_rslt", exrslt, 2 * (c - 1));
      end
      if (c == 6)
        chk("b2b_rv_end", {31'd0, result_valid}, 32'd0);
    end
    chk("b2b_busy_cycles", busy_cnt, 32'd6);

    // Mispredict squash of the S2 op only
    set_op(32'd6, 32'd7, 0, 0, 0, 6'd20, 1, 5'b00010, 1);
    tick();
    set_op(32'd8, 32'd9, 0, 0, 0, 6'd21, 1, 5'b00100, 1);
    tick(); idle();
    prmiss = 1'b1; specfixtag = 5'b00010;
    #1;
    chk("sq1_kill_empty", {31'd0, kill_spec}, 32'd0);
    tick(); idle();
    chk("sq1_rv_dropped", {31'd0, result_valid}, 32'd0);
    tick();
    chk("sq1_rv_keep", {31'd0, result_valid}, 32'd1);
    chk("sq1_dst_keep", {26'd0, exdst}, 32'd21);
    chk("sq1_rslt_keep", exrslt, 32'd72);
    // Second mispredict hits S3, and filters an op issued alongside it
    set_op(32'd1, 32'd1, 0, 0, 0, 6'd22, 1, 5'b00100, 1);
    prmiss = 1'b1; specfixtag = 5'b00100;
    #1;
    chk("sq2_kill", {31'd0, kill_spec}, 32'd1);
    tick(); idle();
    chk("sq2_rv_next", {31'd0, result_valid}, 32'd0);
    chk("sq2_kill_next", {31'd0, kill_spec}, 32'd0);
    chk("sq2_busy", {31'd0, pipe_busy}, 32'd0);

    // Speculation clear while in S2, plus non-matching and same-cycle cases
    set_op(32'd2, 32'd3, 0, 0, 0, 6'd30, 1, 5'b01000, 1);
    tick();
    set_op(32'd4, 32'd5, 0, 0, 0, 6'd31, 1, 5'b10000, 1);
    tick(); idle();
    set_op(32'd6, 32'd6, 0, 0, 0, 6'd32, 1, 5'b01000, 1);
    prsuccess = 1'b1; prtag = 5'b01000;
    tick(); idle();
    chk("ps_rv", {31'd0, result_valid}, 32'd1);
    chk("ps_cleared", {31'd0, out_specbit}, 32'd0);
    chk("ps_rslt", exrslt, 32'd6);
    tick();
    chk("ps_other_dst", {26'd0, exdst}, 32'd31);
    chk("ps_other_spec", {31'd0, out_specbit}, 32'd1);
    tick();
    chk("ps_same_dst", {26'd0, exdst}, 32'd32);
    chk("ps_same_spec", {31'd0, out_specbit}, 32'd0);
    tick();

    // Reset with three ops in flight
    set_op(32'd9, 32'd9, 0, 0, 0, 6'd40, 1, 5'b0, 0);
    tick();
    set_op(32'd8, 32'd8, 0, 0, 0, 6'd41, 1, 5'b0, 1);
    tick();
    set_op(32'd7, 32'd7, 0, 0, 1, 6'd42, 1, 5'b0, 0);
    tick(); idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk_zero("midreset");
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mul_exec_pipe.md
# mul_exec_pipe

Pipelined integer multiply execution unit fed by the two-entry multiply reservation station's issue port. It executes the MUL, MULH, MULHSU and MULHU operations and broadcasts results back to every reservation station on the mul result bus (exrslt/exdst/kill_spec). It also reports completion to the ROB. Each in-flight operation carries its speculation tag, so branch mispredicts squash the operation and branch resolutions clear its speculative flag.

## Interface
- DATA_LEN, 32, operand/result width
- RRF_SEL, 6, rename-register tag width
- SPECTAG_LEN, 5, one-hot speculation tag width
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- issue  in  1  issue strobe from scheduler (RS entry ready and selected this cycle)
- ex_src1, ex_src2  in  DATA_LEN  operands
- src1_signed, src2_signed  in  1  treat operand as signed
- sel_lohi  in  1  0 selects product[DATA_LEN-1:0]; 1 selects product[2*DATA_LEN-1:DATA_LEN]
- rrftag  in  RRF_SEL  destination rename tag
- dstval  in  1  op writes a destination register
- spectag  in  SPECTAG_LEN  speculation tag of op
- specbit  in  1  op is speculative
- prmiss, prsuccess  in  1  branch mispredict / correct-predict this cycle (mutually exclusive)
- prtag  in  SPECTAG_LEN  tag of resolving branch
- specfixtag  in  SPECTAG_LEN  mask of tags invalidated by prmiss
- result_valid  out  1  output stage holds a completed op
- exrslt  out  DATA_LEN  result data
- exdst  out  RRF_SEL  result rename tag
- rrf_we  out  1  result_valid & dstval
- kill_spec  out  1  result on bus is being squashed this cycle; consumers must ignore it
- out_specbit  out  1  speculative flag of output op
- pipe_busy  out  1  any stage valid

## Operation
- Three register stages: S1 (operand capture), S2 (product), S3 (select/output). No backpressure. One op accepted per cycle.
- S1 on issue: sign-extend each operand to DATA_LEN+1 bits (MSB replicated if signed, else 0). Capture the sideband fields: rrftag, dstval, spectag, specbit, sel_lohi.
- S2: full signed product of the two (DATA_LEN+1)-bit values, truncated to 2*DATA_LEN bits.
- S3: register the selected half per sel_lohi. exrslt, exdst, out_specbit and result_valid are driven directly from the S3 registers.
- Sideband fields and a valid bit advance with the data each cycle. A stage whose predecessor is invalid becomes invalid.
- Squash on prmiss:
  - Every stage, including the op entering S1 this cycle, is invalidated when (spectag & specfixtag) != 0.
  - Ops with no overlapping tag bits survive unchanged.
- Speculation clear on prsuccess: every stage and the entering op with spectag == prtag get specbit cleared.
- kill_spec = prmiss & result_valid & ((S3 spectag & specfixtag) != 0). This covers the current bus value; S3 is also invalidated at the next edge.
- The datapath holds its value when a stage is invalid. Only valid bits are qualified.

## Timing
- Reset: all valid bits 0. exrslt=0, exdst=0, result_valid=0, rrf_we=0, kill_spec=0, out_specbit=0, pipe_busy=0.
- Latency: issue sampled at edge t produces result_valid high in the cycle after edge t+2. Result appears 3 cycles after the issue cycle.
- Throughput: 1 op/cycle. Back-to-back issues produce back-to-back results in order.
- Issue together with prmiss: the incoming op is filtered by the same mask rule in the same cycle.
- Issue together with prsuccess on a matching tag: the op enters S1 with specbit=0.
- Reset asserted mid-operation: all in-flight ops are dropped at that edge. No result is broadcast afterwards.
- exrslt/exdst are stable for exactly one cycle per op. Consumers sample when rrf_we & ~kill_spec.

## Test plan
- MUL lo, unsigned×unsigned: 0x0000_0003 × 0x0000_0005, sel_lohi=0, rrftag=7, dstval=1 -> 3 cycles later result_valid=1, rrf_we=1, exrslt=0x0000_000F, exdst=7.
- MULH signed×signed: 0xFFFF_FFFF × 0xFFFF_FFFF, sel_lohi=1 -> exrslt=0x0000_0000. MULHU with the same operands -> 0xFFFF_FFFE. MULHSU (src1 signed) -> 0xFFFF_FFFF.
- Back-to-back issues of 4 ops with tags 1..4 on consecutive cycles -> results with exdst 1,2,3,4 on 4 consecutive cycles, pipe_busy high for 6 cycles.
- Ops with spectag 0b00010 and 0b00100 in S2 and S1, then prmiss with specfixtag=0b00010 -> only the 0b00100 op completes. A second prmiss hitting an S3 op -> kill_spec=1 that cycle, nothing in the next cycle.
- Speculative op (specbit=1, spectag=0b01000), then prsuccess with prtag=0b01000 while in S2 -> out_specbit=0 at completion.
- reset asserted while 3 ops are in flight -> result_valid stays 0 for all following cycles, and all outputs are zero.
